// File: rtl/bt_pkg.sv
// Shared baseband package: correlator state encoding, sync-word sizes and the
// link-state based sync-word selection also used by the TX sync insertion.
package bt_pkg;

  localparam int SW_W  = 64;
  localparam int ERR_W = 7;
  localparam logic [ERR_W-1:0] FILL_FULL = 7'd64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    SEARCH = 2'd2,
    FOUND  = 2'd3
  } corr_state_e;

  function automatic logic [SW_W-1:0] select_syncword(
    input logic            conns,
    input logic            page,
    input logic            ps,
    input logic            mpr,
    input logic            spr,
    input logic            inquiry_diac,
    input logic [SW_W-1:0] sw_cac,
    input logic [SW_W-1:0] sw_dac,
    input logic [SW_W-1:0] sw_diac,
    input logic [SW_W-1:0] sw_giac
  );
    logic [SW_W-1:0] sw;
    if (conns) begin
      sw = sw_cac;
    end else if (page | ps | mpr | spr) begin
      sw = sw_dac;
    end else if (inquiry_diac) begin
      sw = sw_diac;
    end else begin
      sw = sw_giac;
    end
    return sw;
  endfunction

endpackage

// File: rtl/popcount64.sv
// Mismatch counter: number of differing bits between the shift register and
// the selected sync word.
module popcount64
  import bt_pkg::*;
(
  input  logic [SW_W-1:0]  i_a,
  input  logic [SW_W-1:0]  i_b,
  output logic [ERR_W-1:0] o_cnt
);

  // Sum of XOR bits; the caller registers the result.
  always_comb begin
    o_cnt = {ERR_W{1'b0}};
    for (int i = 0; i < SW_W; i++) begin
      o_cnt = o_cnt + {{(ERR_W-1){1'b0}}, i_a[i] ^ i_b[i]};
    end
  end

endmodule

// File: rtl/syncword_correlator.sv
// Access-code correlator: shifts rxbit, compares against the selected sync word
// inside a search window and flags the trailer start to the header stage.
// Optional macro SYNCCORR_STATS_EN adds saturating find/timeout counters.
module syncword_correlator
  import bt_pkg::*;
#(
  parameter int WIN_W = 12
) (
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             p_1us,
  input  logic             rxbit,
  input  logic             rx_search_st_p,
  input  logic             rx_search_abort,
  input  logic             page,
  input  logic             ps,
  input  logic             mpr,
  input  logic             spr,
  input  logic             conns,
  input  logic             regi_inquiryDIAC,
  input  logic [SW_W-1:0]  regi_syncword_CAC,
  input  logic [SW_W-1:0]  regi_syncword_DAC,
  input  logic [SW_W-1:0]  regi_syncword_DIAC,
  input  logic [SW_W-1:0]  regi_syncword_GIAC,
  input  logic [ERR_W-1:0] regi_corr_threshold,
  input  logic [WIN_W-1:0] regi_search_win,
  output logic             rx_trailer_st_p,
  output logic             sync_found,
  output logic             sync_timeout_p,
  output logic [ERR_W-1:0] corr_err,
  output logic             search_active
`ifdef SYNCCORR_STATS_EN
  ,
  output logic [15:0]      sync_found_cnt,
  output logic [15:0]      sync_timeout_cnt
`endif
);

  corr_state_e      r_state, w_state_nxt;
  logic [SW_W-1:0]  r_sr, r_syncword;
  logic [ERR_W-1:0] r_fill_cnt, r_corr_err, w_popcnt;
  logic [WIN_W-1:0] r_win_cnt;
  logic             r_v0, r_v1;
  logic             r_trailer, r_found, r_timeout, r_active;
  logic             w_trailer_nxt, w_found_nxt, w_timeout_nxt, w_active_nxt;
  logic             w_restart, w_searching, w_shift, w_eval, w_match, w_expire;
  logic             w_match_evt, w_expire_evt;

  popcount64 u_popcount (
    .i_a   (r_sr),
    .i_b   (r_syncword),
    .o_cnt (w_popcnt)
  );

  assign w_restart    = rx_search_st_p & ~rx_search_abort;
  assign w_searching  = (r_state == FILL) || (r_state == SEARCH);
  assign w_shift      = p_1us & w_searching;
  assign w_eval       = r_v1 & w_searching;
  assign w_match      = w_eval & (r_fill_cnt == FILL_FULL) & (r_corr_err <= regi_corr_threshold);
  assign w_expire     = w_eval & ~w_match & (r_win_cnt >= regi_search_win);
  assign w_match_evt  = w_match & ~rx_search_abort & ~rx_search_st_p;
  assign w_expire_evt = w_expire & ~rx_search_abort & ~rx_search_st_p;

  // Bit pipeline: shift at T, mismatch count at T+1, decision at T+2.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_sr       <= {SW_W{1'b0}};
      r_syncword <= {SW_W{1'b0}};
      r_fill_cnt <= {ERR_W{1'b0}};
      r_win_cnt  <= {WIN_W{1'b0}};
      r_corr_err <= {ERR_W{1'b0}};
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
    end else if (w_restart) begin
      r_sr       <= {SW_W{1'b0}};
      r_syncword <= select_syncword(conns, page, ps, mpr, spr, regi_inquiryDIAC,
                                    regi_syncword_CAC, regi_syncword_DAC,
                                    regi_syncword_DIAC, regi_syncword_GIAC);
      r_fill_cnt <= {ERR_W{1'b0}};
      r_win_cnt  <= {WIN_W{1'b0}};
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
    end else if (rx_search_abort) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
    end else begin
      if (w_shift) begin
        r_sr <= {r_sr[SW_W-2:0], rxbit};
        if (r_fill_cnt != FILL_FULL) r_fill_cnt <= r_fill_cnt + 7'd1;
        if (r_win_cnt != {WIN_W{1'b1}}) r_win_cnt <= r_win_cnt + {{(WIN_W-1){1'b0}}, 1'b1};
      end
      if (r_v0) r_corr_err <= w_popcnt;
      r_v0 <= w_shift;
      r_v1 <= r_v0;
    end
  end

  // State register.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: abort beats restart, restart beats everything else.
  always_comb begin
    w_state_nxt = r_state;
    if (rx_search_abort) begin
      w_state_nxt = IDLE;
    end else if (rx_search_st_p) begin
      w_state_nxt = FILL;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        FILL:    w_state_nxt = w_expire ? IDLE : ((r_fill_cnt == FILL_FULL) ? SEARCH : FILL);
        SEARCH:  w_state_nxt = w_match ? FOUND : (w_expire ? IDLE : SEARCH);
        FOUND:   w_state_nxt = p_1us ? IDLE : FOUND;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output decode; the trailer is held until the consumer's next p_1us.
  always_comb begin
    w_trailer_nxt = r_trailer;
    w_found_nxt   = r_found;
    w_timeout_nxt = 1'b0;
    if (rx_search_abort) begin
      w_trailer_nxt = 1'b0;
    end else if (rx_search_st_p) begin
      w_trailer_nxt = 1'b0;
      w_found_nxt   = 1'b0;
    end else if (w_match) begin
      w_trailer_nxt = 1'b1;
      w_found_nxt   = 1'b1;
    end else if (w_expire) begin
      w_timeout_nxt = 1'b1;
    end else if ((r_state == FOUND) && p_1us) begin
      w_trailer_nxt = 1'b0;
    end else begin
      w_trailer_nxt = r_trailer;
    end
    w_active_nxt = (w_state_nxt == FILL) || (w_state_nxt == SEARCH);
  end

  // Registered outputs.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_trailer <= 1'b0;
      r_found   <= 1'b0;
      r_timeout <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_trailer <= w_trailer_nxt;
      r_found   <= w_found_nxt;
      r_timeout <= w_timeout_nxt;
      r_active  <= w_active_nxt;
    end
  end

  assign rx_trailer_st_p = r_trailer;
  assign sync_found      = r_found;
  assign sync_timeout_p  = r_timeout;
  assign corr_err        = r_corr_err;
  assign search_active   = r_active;

`ifdef SYNCCORR_STATS_EN
  logic [15:0] r_found_cnt, r_timeout_cnt;

  // Saturating event counters, cleared by reset only.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_found_cnt   <= 16'd0;
      r_timeout_cnt <= 16'd0;
    end else begin
      if (w_match_evt && (r_found_cnt != 16'hFFFF)) r_found_cnt <= r_found_cnt + 16'd1;
      if (w_expire_evt && (r_timeout_cnt != 16'hFFFF)) r_timeout_cnt <= r_timeout_cnt + 16'd1;
    end
  end

  assign sync_found_cnt   = r_found_cnt;
  assign sync_timeout_cnt = r_timeout_cnt;
`endif

endmodule
